// File: rtl/lsu_mem_stage.sv
// Load/store unit between EX and a word-addressed DMEM without byte enables.
// Sub-word stores are done as read-modify-write; illegal requests never touch DMEM.
module lsu_mem_stage #(
   parameter int unsigned WORDS_LOG2 = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic        req_re,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic [31:0] load_data,
   output logic        load_valid,
   output logic        store_done,
   output logic        err,
   output logic [31:0] DMEM_address,
   output logic [31:0] DMEM_data_in,
   output logic        DMEM_mem_write,
   output logic        DMEM_mem_read,
   input  logic [31:0] DMEM_data_out
);

   typedef enum logic [2:0] {IDLE, LOAD, MERGE, WRITE, ERR} state_t;

   state_t      state;
   logic [1:0]  lat_size;
   logic [1:0]  lat_off;
   logic        lat_unsigned;
   logic [15:0] lat_wdata;

   logic        take;
   logic        req_bad;
   logic [31:0] word_idx;

   // we&re together must still be taken so it can be reported as an error
   assign take = req_valid & req_ready & (req_we | req_re);

   always_comb begin
      req_bad = (req_we & req_re)
              | (req_size == 2'b11)
              | ((req_size == 2'b01) & req_addr[0])
              | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00))
              | (req_addr[31:WORDS_LOG2+2] != '0);
   end

   always_comb begin
      word_idx = '0;
      word_idx[WORDS_LOG2-1:0] = req_addr[WORDS_LOG2+1:2];
   end

   function automatic logic [31:0] lane_extract(input logic [31:0] w, input logic [1:0] sz,
                                                input logic [1:0] off, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{off, 3'b000} +: 8];
      h = off[1] ? w[31:16] : w[15:0];
      case (sz)
         2'b00:   lane_extract = {{24{~uns & b[7]}}, b};
         2'b01:   lane_extract = {{16{~uns & h[15]}}, h};
         default: lane_extract = w;
      endcase
   endfunction

   function automatic logic [31:0] lane_merge(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [1:0] off, input logic [15:0] wd);
      logic [31:0] m;
      m = w;
      if (sz == 2'b00)
         m[{off, 3'b000} +: 8] = wd[7:0];
      else
         m[{off[1], 4'b0000} +: 16] = wd;
      lane_merge = m;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         req_ready      <= 1'b1;
         load_data      <= '0;
         load_valid     <= 1'b0;
         store_done     <= 1'b0;
         err            <= 1'b0;
         DMEM_address   <= '0;
         DMEM_data_in   <= '0;
         DMEM_mem_write <= 1'b0;
         DMEM_mem_read  <= 1'b0;
         lat_size       <= '0;
         lat_off        <= '0;
         lat_unsigned   <= 1'b0;
         lat_wdata      <= '0;
      end else begin
         load_valid <= 1'b0;
         store_done <= 1'b0;
         err        <= 1'b0;
         case (state)
            IDLE: begin
               if (take) begin
                  lat_size     <= req_size;
                  lat_off      <= req_addr[1:0];
                  lat_unsigned <= req_unsigned;
                  lat_wdata    <= req_wdata[15:0];
                  req_ready    <= 1'b0;
                  if (req_bad) begin
                     state <= ERR;
                     err   <= 1'b1;
                  end else if (req_re) begin
                     state         <= LOAD;
                     DMEM_mem_read <= 1'b1;
                     DMEM_address  <= word_idx;
                  end else if (req_size == 2'b10) begin
                     state          <= WRITE;
                     DMEM_mem_write <= 1'b1;
                     DMEM_data_in   <= req_wdata;
                     DMEM_address   <= word_idx;
                     store_done     <= 1'b1;
                  end else begin
                     state         <= MERGE;
                     DMEM_mem_read <= 1'b1;
                     DMEM_address  <= word_idx;
                  end
               end
            end
            LOAD: begin
               load_data     <= lane_extract(DMEM_data_out, lat_size, lat_off, lat_unsigned);
               load_valid    <= 1'b1;
               DMEM_mem_read <= 1'b0;
               DMEM_address  <= '0;
               req_ready     <= 1'b1;
               state         <= IDLE;
            end
            MERGE: begin
               DMEM_data_in   <= lane_merge(DMEM_data_out, lat_size, lat_off, lat_wdata);
               DMEM_mem_read  <= 1'b0;
               DMEM_mem_write <= 1'b1;
               store_done     <= 1'b1;
               state          <= WRITE;
            end
            WRITE: begin
               DMEM_mem_write <= 1'b0;
               DMEM_data_in   <= '0;
               DMEM_address   <= '0;
               req_ready      <= 1'b1;
               state          <= IDLE;
            end
            ERR: begin
               req_ready <= 1'b1;
               state     <= IDLE;
            end
            default: begin
               DMEM_mem_read  <= 1'b0;
               DMEM_mem_write <= 1'b0;
               req_ready      <= 1'b1;
               state          <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage with a behavioural DMEM and shadow memory.
module tb_lsu_mem_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, req_we = 1'b0, req_re = 1'b0, req_unsigned = 1'b0;
   logic [1:0]  req_size = '0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        req_ready, load_valid, store_done, err;
   logic [31:0] load_data, DMEM_address, DMEM_data_in, DMEM_data_out;
   logic        DMEM_mem_write, DMEM_mem_read;

   lsu_mem_stage #(.WORDS_LOG2(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_we(req_we), .req_re(req_re),
      .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .load_data(load_data), .load_valid(load_valid),
      .store_done(store_done), .err(err),
      .DMEM_address(DMEM_address), .DMEM_data_in(DMEM_data_in),
      .DMEM_mem_write(DMEM_mem_write), .DMEM_mem_read(DMEM_mem_read),
      .DMEM_data_out(DMEM_data_out)
   );

   always #5 clk = ~clk;

   logic [31:0] mem    [256];
   logic [31:0] shadow [256];
   initial for (int i = 0; i < 256; i++) begin mem[i] = '0; shadow[i] = '0; end

   always @(posedge clk) if (DMEM_mem_write) mem[DMEM_address[7:0]] <= DMEM_data_in;
   assign DMEM_data_out = mem[DMEM_address[7:0]];

   typedef struct {
      logic [2:0]  kind;   // {load_valid, store_done, err}
      int          cyc;
      logic [31:0] data;
      logic [31:0] addr;
   } exp_t;
   exp_t sbq[$];

   int cyc = 0;
   int checks = 0, errors = 0;
   int reads = 0, writes = 0, exp_reads = 0, exp_writes = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic ref_bad(input logic we, input logic re, input logic [1:0] sz,
                                    input logic [31:0] a);
      return (we && re) || sz == 2'b11 || (sz == 2'b01 && a[0]) ||
             (sz == 2'b10 && a[1:0] != 2'b00) || a[31:10] != 22'd0;
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [31:0] a, input logic uns);
      logic [31:0]        s;
      logic signed [7:0]  sb;
      logic signed [15:0] sh;
      logic signed [31:0] r;
      s = w >> (8 * a[1:0]);
      sb = s[7:0];
      sh = s[15:0];
      if (sz == 2'b10) return w;
      if (sz == 2'b00) begin
         if (uns) return {24'd0, s[7:0]};
         r = sb;
         return r;
      end
      if (uns) return {16'd0, s[15:0]};
      r = sh;
      return r;
   endfunction

   function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] sz,
                                             input logic [31:0] a, input logic [31:0] wd);
      logic [31:0] mask;
      int          sh;
      if (sz == 2'b10) return wd;
      mask = (sz == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
      sh = 8 * a[1:0];
      return (w & ~(mask << sh)) | ((wd & mask) << sh);
   endfunction

   task automatic issue(input logic we, input logic re, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
      exp_t e;
      int   guard;
      req_valid = 1'b1; req_we = we; req_re = re; req_size = sz;
      req_unsigned = uns; req_addr = a; req_wdata = wd;
      guard = 0;
      while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
      check("ready_wait", {31'd0, req_ready}, 32'd1);
      e.addr = {22'd0, a[9:2]};
      e.data = '0;
      if (ref_bad(we, re, sz, a)) begin
         e.kind = 3'b001; e.cyc = cyc + 1;
      end else if (re) begin
         e.kind = 3'b100; e.cyc = cyc + 2;
         e.data = ref_load(shadow[a[9:2]], sz, a, uns);
         exp_reads++;
      end else begin
         e.kind = 3'b010;
         e.data = ref_store(shadow[a[9:2]], sz, a, wd);
         shadow[a[9:2]] = e.data;
         exp_writes++;
         if (sz == 2'b10) e.cyc = cyc + 1;
         else begin e.cyc = cyc + 2; exp_reads++; end
      end
      sbq.push_back(e);
      @(negedge clk);
      req_valid = 1'b0; req_we = 1'b0; req_re = 1'b0;
   endtask

   task automatic drain();
      int guard = 0;
      while ((sbq.size() != 0 || !req_ready) && guard < 50) begin @(negedge clk); guard++; end
      check("drain", sbq.size(), 0);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         exp_t e;
         if (DMEM_mem_read) reads++;
         if (DMEM_mem_write) writes++;
         if (DMEM_mem_read || DMEM_mem_write)
            check("rw_excl", {31'd0, DMEM_mem_read & DMEM_mem_write}, 32'd0);
         if (load_valid || store_done || err) begin
            if (sbq.size() == 0) begin
               check("unexpected_evt", {29'd0, load_valid, store_done, err}, 32'd0);
            end else begin
               e = sbq.pop_front();
               check("evt_kind", {29'd0, load_valid, store_done, err}, {29'd0, e.kind});
               check("evt_cycle", cyc, e.cyc);
               if (e.kind == 3'b100) begin
                  check("load_data", load_data, e.data);
                  check("ready_at_load", {31'd0, req_ready}, 32'd1);
               end else if (e.kind == 3'b010) begin
                  check("store_word", DMEM_data_in, e.data);
                  check("store_addr", DMEM_address, e.addr);
                  check("store_strobe", {31'd0, DMEM_mem_write}, 32'd1);
                  check("ready_at_store", {31'd0, req_ready}, 32'd0);
               end else begin
                  check("err_no_dmem", {30'd0, DMEM_mem_read, DMEM_mem_write}, 32'd0);
                  check("ready_at_err", {31'd0, req_ready}, 32'd0);
               end
            end
         end
      end
   end

   initial begin
      int nbad;
      repeat (3) @(negedge clk);
      check("rst_ready", {31'd0, req_ready}, 32'd1);
      check("rst_load_data", load_data, 32'd0);
      check("rst_pulses", {29'd0, load_valid, store_done, err}, 32'd0);
      check("rst_dmem_addr", DMEM_address, 32'd0);
      check("rst_dmem_data", DMEM_data_in, 32'd0);
      check("rst_dmem_rw", {30'd0, DMEM_mem_read, DMEM_mem_write}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // word store then word load
      issue(1, 0, 2'b10, 0, 32'h10, 32'hDEADBEEF);
      issue(0, 1, 2'b10, 0, 32'h10, 32'h0);
      drain();

      // byte store read-modify-write
      issue(1, 0, 2'b10, 0, 32'h10, 32'h11223344);
      issue(1, 0, 2'b00, 0, 32'h12, 32'h000000AB);
      issue(0, 1, 2'b10, 0, 32'h10, 32'h0);
      drain();

      // sub-word load extension
      issue(1, 0, 2'b10, 0, 32'h10, 32'h8000FF7F);
      issue(0, 1, 2'b00, 0, 32'h10, 32'h0);
      issue(0, 1, 2'b00, 0, 32'h11, 32'h0);
      issue(0, 1, 2'b01, 1, 32'h12, 32'h0);
      issue(0, 1, 2'b01, 0, 32'h12, 32'h0);
      issue(0, 1, 2'b00, 1, 32'h13, 32'h0);
      drain();

      // rejected requests
      issue(0, 1, 2'b01, 0, 32'h13, 32'h0);
      issue(1, 0, 2'b10, 0, 32'h402, 32'h12345678);
      issue(0, 1, 2'b11, 0, 32'h10, 32'h0);
      issue(1, 1, 2'b10, 0, 32'h10, 32'hFFFFFFFF);
      issue(0, 1, 2'b10, 0, 32'h400, 32'h0);
      drain();

      // valid without we/re is ignored
      req_valid = 1'b1; req_addr = 32'h10;
      @(negedge clk);
      req_valid = 1'b0;
      check("ignored_ready", {31'd0, req_ready}, 32'd1);
      @(negedge clk);

      // back-to-back, including top-of-memory word
      issue(1, 0, 2'b10, 0, 32'h20, 32'hCAFEF00D);
      issue(1, 0, 2'b01, 0, 32'h22, 32'h0000BEEF);
      issue(0, 1, 2'b10, 0, 32'h20, 32'h0);
      issue(1, 0, 2'b10, 0, 32'h3FC, 32'hA5A5_5A5A);
      issue(1, 0, 2'b00, 0, 32'h3FF, 32'h0000_0033);
      issue(0, 1, 2'b10, 1, 32'h3FC, 32'h0);
      drain();

      // reset during MERGE aborts the store
      check("pre_abort_ready", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h10; req_wdata = 32'h55;
      @(negedge clk);
      req_valid = 1'b0; req_we = 1'b0;
      exp_reads++;
      #2 rst_n = 1'b0;
      #1 check("abort_write_low", {31'd0, DMEM_mem_write}, 32'd0);
      repeat (2) @(negedge clk);
      check("abort_write_rst", {31'd0, DMEM_mem_write}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_ready", {31'd0, req_ready}, 32'd1);
      check("abort_load_data", load_data, 32'd0);
      check("abort_word4", mem[4], shadow[4]);
      repeat (3) @(negedge clk);

      check("sb_empty", sbq.size(), 0);
      check("read_count", reads, exp_reads);
      check("write_count", writes, exp_writes);
      nbad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== shadow[i]) nbad++;
      check("mem_final", nbad, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
